// File: rtl/sha3_sponge_ctrl.sv
// Purpose : SHA3 sponge sequencer: absorbs AXI-Stream words into the rate lanes, pads, runs Keccak rounds, hands off to squeeze.
// Latency : first pad word 1 cycle after the TLAST beat; permutation takes ROUNDS cycles; out_ready rises the cycle after the last round.
// Backpressure: S_TREADY is high only in ABSORB; SQUEEZE holds out_ready until out_last. Optional SHA_CTRL_BLKCNT_EN adds blk_cnt[15:0].
module sha3_sponge_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ROUNDS     = 24
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  input  logic [DATA_WIDTH-1:0] S_TDATA,
  input  logic                  S_TLAST,
  input  logic [1:0]            S_TID,
  input  logic                  mode_in,
  output logic                  state_clr,
  output logic                  absorb_we,
  output logic [7:0]            absorb_idx,
  output logic [DATA_WIDTH-1:0] absorb_data,
  output logic                  round_en,
  output logic [4:0]            round_idx,
  output logic                  out_ready,
  output logic [1:0]            out_tid,
  output logic                  out_mode,
  input  logic                  out_last,
`ifdef SHA_CTRL_BLKCNT_EN
  output logic                  busy,
  output logic [15:0]           blk_cnt
`else
  output logic                  busy
`endif
);

  // Words per rate block are rate_bits >> log2(DATA_WIDTH).
  localparam int WSHIFT = (DATA_WIDTH == 16) ? 4 : (DATA_WIDTH == 32) ? 5 : 6;
  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);
  localparam logic [DATA_WIDTH-1:0] PAD_FIRST = {{(DATA_WIDTH-8){1'b0}}, 8'h06};
  localparam logic [DATA_WIDTH-1:0] PAD_LAST  = {8'h80, {(DATA_WIDTH-8){1'b0}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ABSORB  = 3'd2,
    PAD     = 3'd3,
    PERMUTE = 3'd4,
    SQUEEZE = 3'd5
  } state_t;

  // Index of the last rate word for a given SHA3 variant.
  function automatic logic [7:0] rate_last(input logic [1:0] tid);
    logic [10:0] bits;
    case (tid)
      2'd0:    bits = 11'd1152;
      2'd1:    bits = 11'd1088;
      2'd2:    bits = 11'd832;
      default: bits = 11'd576;
    endcase
    return 8'((bits >> WSHIFT) - 11'd1);
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [4:0]  rnd_q, rnd_d;
  logic [7:0]  rlast_q, rlast_d;
  logic [1:0]  tid_q, tid_d;
  logic        mode_q, mode_d;
  logic        msg_done_q, msg_done_d;   // TLAST beat already absorbed
  logic        pad_blk_q, pad_blk_d;     // an all-padding block follows this permutation
  logic        pad_first_q, pad_first_d; // next pad word carries the 0x06 domain byte
  logic        tready_q, tready_d;
  logic        clr_q, clr_d;
  logic        ren_q, ren_d;
  logic        oready_q, oready_d;
  logic        busy_q, busy_d;
`ifdef SHA_CTRL_BLKCNT_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;
`endif

  logic beat_hs;
  assign beat_hs = tready_q & S_TVALID;

  // Sequencer next state, counters, latched stream attributes and registered output decodes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rnd_d       = rnd_q;
    rlast_d     = rlast_q;
    tid_d       = tid_q;
    mode_d      = mode_q;
    msg_done_d  = msg_done_q;
    pad_blk_d   = pad_blk_q;
    pad_first_d = pad_first_q;
`ifdef SHA_CTRL_BLKCNT_EN
    blk_cnt_d   = blk_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // The first beat is only observed here; it is consumed in ABSORB.
        if (S_TVALID) begin
          state_d     = CLEAR;
          tid_d       = S_TID;
          mode_d      = mode_in;
          rlast_d     = rate_last(S_TID);
          idx_d       = '0;
          rnd_d       = '0;
          msg_done_d  = 1'b0;
          pad_blk_d   = 1'b0;
          pad_first_d = 1'b0;
        end
      end
      CLEAR: begin
        state_d = ABSORB;
        idx_d   = '0;
`ifdef SHA_CTRL_BLKCNT_EN
        blk_cnt_d = '0;
`endif
      end
      ABSORB: begin
        if (beat_hs) begin
          if (S_TLAST) begin
            msg_done_d = 1'b1;
            if (idx_q == rlast_q) begin
              // Block is full: padding needs a whole extra block.
              state_d   = PERMUTE;
              pad_blk_d = 1'b1;
              idx_d     = '0;
              rnd_d     = '0;
            end else begin
              state_d     = PAD;
              pad_first_d = 1'b1;
              idx_d       = idx_q + 8'd1;
            end
          end else if (idx_q == rlast_q) begin
            state_d = PERMUTE;
            idx_d   = '0;
            rnd_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      PAD: begin
        pad_first_d = 1'b0;
        if (idx_q == rlast_q) begin
          state_d = PERMUTE;
          idx_d   = '0;
          rnd_d   = '0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      PERMUTE: begin
        if (rnd_q == LAST_RND) begin
          rnd_d = '0;
`ifdef SHA_CTRL_BLKCNT_EN
          if (blk_cnt_q != 16'hFFFF) blk_cnt_d = blk_cnt_q + 16'd1;
`endif
          if (!msg_done_q) begin
            state_d = ABSORB;
          end else if (pad_blk_q) begin
            state_d     = PAD;
            pad_blk_d   = 1'b0;
            pad_first_d = 1'b1;
          end else begin
            state_d = SQUEEZE;
          end
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      SQUEEZE: begin
        if (out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tready_d = (state_d == ABSORB);
    clr_d    = (state_d == CLEAR);
    ren_d    = (state_d == PERMUTE);
    oready_d = (state_d == SQUEEZE);
    busy_d   = (state_d != IDLE);
  end

  // Absorb port: message word on a handshake, generated pad word in PAD, zero otherwise.
  always_comb begin
    absorb_we   = 1'b0;
    absorb_data = '0;
    if (beat_hs) begin
      absorb_we   = 1'b1;
      absorb_data = S_TDATA;
    end else if (state_q == PAD) begin
      absorb_we = 1'b1;
      if (pad_first_q)       absorb_data = absorb_data | PAD_FIRST;
      if (idx_q == rlast_q)  absorb_data = absorb_data | PAD_LAST;
    end
  end

  // State register; reset aborts any message in flight.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rnd_q       <= '0;
      rlast_q     <= '0;
      tid_q       <= '0;
      mode_q      <= 1'b0;
      msg_done_q  <= 1'b0;
      pad_blk_q   <= 1'b0;
      pad_first_q <= 1'b0;
      tready_q    <= 1'b0;
      clr_q       <= 1'b0;
      ren_q       <= 1'b0;
      oready_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SHA_CTRL_BLKCNT_EN
      blk_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rnd_q       <= rnd_d;
      rlast_q     <= rlast_d;
      tid_q       <= tid_d;
      mode_q      <= mode_d;
      msg_done_q  <= msg_done_d;
      pad_blk_q   <= pad_blk_d;
      pad_first_q <= pad_first_d;
      tready_q    <= tready_d;
      clr_q       <= clr_d;
      ren_q       <= ren_d;
      oready_q    <= oready_d;
      busy_q      <= busy_d;
`ifdef SHA_CTRL_BLKCNT_EN
      blk_cnt_q   <= blk_cnt_d;
`endif
    end
  end

  assign S_TREADY   = tready_q;
  assign state_clr  = clr_q;
  assign absorb_idx = idx_q;
  assign round_en   = ren_q;
  assign round_idx  = rnd_q;
  assign out_ready  = oready_q;
  assign out_tid    = tid_q;
  assign out_mode   = mode_q;
  assign busy       = busy_q;
`ifdef SHA_CTRL_BLKCNT_EN
  assign blk_cnt    = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Bench for sha3_sponge_ctrl (DATA_WIDTH=64, ROUNDS=24).
// Expected absorb writes (message + pad words) are queued as each message is driven
// and popped by a negedge monitor whenever absorb_we is high.
module tb_sha3_sponge_ctrl;

  logic        ACLK;
  logic        ARESET;
  logic        S_TVALID;
  logic        S_TREADY;
  logic [63:0] S_TDATA;
  logic        S_TLAST;
  logic [1:0]  S_TID;
  logic        mode_in;
  logic        state_clr;
  logic        absorb_we;
  logic [7:0]  absorb_idx;
  logic [63:0] absorb_data;
  logic        round_en;
  logic [4:0]  round_idx;
  logic        out_ready;
  logic [1:0]  out_tid;
  logic        out_mode;
  logic        out_last;
  logic        busy;
`ifdef SHA_CTRL_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  sha3_sponge_ctrl #(.DATA_WIDTH(64), .ROUNDS(24)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA),
    .S_TLAST(S_TLAST), .S_TID(S_TID), .mode_in(mode_in),
    .state_clr(state_clr), .absorb_we(absorb_we), .absorb_idx(absorb_idx),
    .absorb_data(absorb_data), .round_en(round_en), .round_idx(round_idx),
    .out_ready(out_ready), .out_tid(out_tid), .out_mode(out_mode),
    .out_last(out_last),
`ifdef SHA_CTRL_BLKCNT_EN
    .busy(busy), .blk_cnt(blk_cnt)
`else
    .busy(busy)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [71:0] exp_q[$];
  logic [71:0] sb_e;
  int rnd_total = 0;
  int rnd_exp = 0;
  int first_rnd_cyc = 0;
  int last_rnd_cyc = 0;
  int last_we_cyc = 0;
  int clr_cnt = 0;
  int sq_cyc = 0;
  int hs_cyc[64];
  int t0;
  int g;

  always @(posedge ACLK) cyc++;

  task automatic check(input string name, input logic [71:0] obs, input logic [71:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  function automatic int rate_words(input logic [1:0] tid);
    case (tid)
      2'd0:    return 18;
      2'd1:    return 17;
      2'd2:    return 13;
      default: return 9;
    endcase
  endfunction

  function automatic logic [63:0] wordf(input logic [63:0] w0, input int i);
    return w0 + 64'h0101_0101_0000_0000 * 64'(i);
  endfunction

  // Queue every absorb write the message should produce, pads included.
  task automatic expect_msg(input logic [1:0] tid, input int n, input logic [63:0] w0);
    int r = rate_words(tid);
    int idx = 0;
    int last;
    int start;
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(idx), wordf(w0, i)});
      idx = (idx == r - 1) ? 0 : idx + 1;
    end
    last  = (n - 1) % r;
    start = (last < r - 1) ? last + 1 : 0;
    for (int j = start; j < r; j++) begin
      d = '0;
      if (j == start) d[7:0]   = 8'h06;
      if (j == r - 1) d[63:56] = 8'h80;
      exp_q.push_back({8'(j), d});
    end
  endtask

  // Monitor: scoreboard pops, exclusivity, idle-zero data, round index sequence.
  always @(negedge ACLK) begin
    if (mon_en) begin
      check("we_ren_exclusive", {7'd0, absorb_we & round_en}, 72'd0);
      if (!absorb_we) check("data_zero_when_idle", absorb_data, 72'd0);
      if (absorb_we) begin
        check("sb_has_entry", (exp_q.size() != 0), 72'd1);
        if (exp_q.size() != 0) begin
          sb_e = exp_q.pop_front();
          check("absorb_idx", absorb_idx, sb_e[71:64]);
          check("absorb_data", absorb_data, sb_e[63:0]);
        end
        last_we_cyc = cyc;
      end
      if (state_clr) clr_cnt++;
      if (round_en) begin
        check("round_idx", round_idx, rnd_exp);
        if (rnd_total == 0) first_rnd_cyc = cyc;
        last_rnd_cyc = cyc;
        rnd_total++;
        rnd_exp = (rnd_exp == 23) ? 0 : rnd_exp + 1;
      end else begin
        rnd_exp = 0;
      end
    end
  end

  task automatic send_msg(input logic [1:0] tid, input logic mode, input int n,
                          input logic [63:0] w0, input bit toggle);
    int gw;
    expect_msg(tid, n, w0);
    rnd_total = 0;
    clr_cnt   = 0;
    @(posedge ACLK); #1;
    S_TID    = tid;
    mode_in  = mode;
    S_TVALID = 1'b1;
    for (int i = 0; i < n; i++) begin
      S_TDATA = wordf(w0, i);
      S_TLAST = (i == n - 1);
      gw = 0;
      @(negedge ACLK);
      while (!S_TREADY && gw < 1000) begin
        @(negedge ACLK);
        gw++;
      end
      check("beat_accepted", (gw < 1000), 72'd1);
      if (gw >= 1000) break;
      hs_cyc[i] = cyc;
      @(posedge ACLK); #1;
      if (toggle) begin
        S_TID   = ~tid;
        mode_in = ~mode;
      end
    end
    S_TVALID = 1'b0;
    S_TLAST  = 1'b0;
    S_TDATA  = '0;
  endtask

  task automatic finish_msg(input logic [1:0] tid, input logic mode, input int nblk,
                            input int hold, input bit poke);
    int gw = 0;
    @(negedge ACLK);
    while (!out_ready && gw < 2000) begin
      @(negedge ACLK);
      gw++;
    end
    check("out_ready_rises", (gw < 2000), 72'd1);
    sq_cyc = cyc;
    check("out_tid", out_tid, tid);
    check("out_mode", out_mode, mode);
    check("sq_busy_tready", {busy, S_TREADY}, 72'b10);
    check("sb_drained", exp_q.size(), 72'd0);
    check("round_count", rnd_total, 24 * nblk);
    check("clr_pulses", clr_cnt, 72'd1);
    if (poke) begin
      S_TVALID = 1'b1;
      S_TDATA  = 64'hDEAD_BEEF_0BAD_F00D;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge ACLK);
      check("sq_hold", {out_ready, S_TREADY}, 72'b10);
    end
    S_TVALID = 1'b0;
    S_TDATA  = '0;
    @(posedge ACLK); #1;
    out_last = 1'b1;
    @(negedge ACLK);
    check("out_ready_with_last", out_ready, 72'd1);
    @(posedge ACLK); #1;
    out_last = 1'b0;
    @(negedge ACLK);
    check("idle_after_last", {out_ready, busy}, 72'd0);
`ifdef SHA_CTRL_BLKCNT_EN
    check("blk_cnt", blk_cnt, nblk);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET   = 1'b1;
    S_TVALID = 1'b0;
    S_TDATA  = '0;
    S_TLAST  = 1'b0;
    S_TID    = 2'd0;
    mode_in  = 1'b0;
    out_last = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    // Reset state
    @(negedge ACLK);
    check("rst_tready", S_TREADY, 72'd0);
    check("rst_clr", state_clr, 72'd0);
    check("rst_we", absorb_we, 72'd0);
    check("rst_idx", absorb_idx, 72'd0);
    check("rst_data", absorb_data, 72'd0);
    check("rst_round", {round_en, round_idx}, 72'd0);
    check("rst_out", {out_ready, out_tid, out_mode}, 72'd0);
    check("rst_busy", busy, 72'd0);
`ifdef SHA_CTRL_BLKCNT_EN
    check("rst_blk_cnt", blk_cnt, 72'd0);
`endif
    mon_en = 1'b1;

    // SHA3-256, one word: latency profile, then a long squeeze with S_TVALID poked
    send_msg(2'd1, 1'b1, 1, 64'h0000_0000_0063_6261, 1'b0);
    t0 = hs_cyc[0];
    finish_msg(2'd1, 1'b1, 1, 200, 1'b1);
    check("lat_last_pad", last_we_cyc, t0 + 16);
    check("lat_first_round", first_rnd_cyc, t0 + 17);
    check("lat_last_round", last_rnd_cyc, t0 + 40);
    check("lat_out_ready", sq_cyc, t0 + 41);

    // SHA3-256, 17 words: full block then an all-padding block
    send_msg(2'd1, 1'b0, 17, 64'h1111_2222_3333_4444, 1'b0);
    finish_msg(2'd1, 1'b0, 2, 4, 1'b0);

    // SHA3-512, 8 words: single combined 0x80..06 pad word at idx 8
    send_msg(2'd3, 1'b0, 8, 64'hA5A5_0000_5A5A_0001, 1'b0);
    finish_msg(2'd3, 1'b0, 1, 2, 1'b0);

    // SHA3-224, 20 words, TID/mode toggled after first beat
    send_msg(2'd0, 1'b1, 20, 64'h0F0F_F0F0_1234_5678, 1'b1);
    check("stall_gap", hs_cyc[18] - hs_cyc[17], 72'd25);
    check("no_stall_gap", hs_cyc[17] - hs_cyc[16], 72'd1);
    finish_msg(2'd0, 1'b1, 2, 3, 1'b0);

    // Reset during round 10 of a permutation, then a fresh SHA3-384 message
    send_msg(2'd1, 1'b0, 1, 64'h0000_0000_0000_0077, 1'b0);
    g = 0;
    @(negedge ACLK);
    while (!(round_en && round_idx == 5'd9) && g < 500) begin
      @(negedge ACLK);
      g++;
    end
    check("reached_round9", (g < 500), 72'd1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("abort_outputs", {round_en, busy, S_TREADY, out_ready, state_clr}, 72'd0);
    exp_q.delete();
    send_msg(2'd2, 1'b1, 3, 64'h5555_6666_7777_8888, 1'b0);
    finish_msg(2'd2, 1'b1, 1, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
